// File: rtl/seven_seg_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | seven_seg_pkg                                                         |
// | Shared types and constants for the seven-segment display path.        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package seven_seg_pkg;

  localparam int DIGIT_W   = 4;
  localparam int DISPLAY_W = 4 * DIGIT_W;

  localparam logic [DISPLAY_W-1:0] IDLE_VAL_DEFAULT = 16'h0000;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rr_picker                                                             |
// | First set bit of mask searching upward from ptr+1 with wrap-around.   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module rr_picker #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    mask,
  input  logic [ID_W-1:0] ptr,
  output logic            found,
  output logic [ID_W-1:0] idx
);

  logic [ID_W-1:0] w_cand;

  // Walk from the farthest slot back to ptr+1 so the nearest hit wins last.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    w_cand = '0;
    for (int k = N; k >= 1; k--) begin
      w_cand = ID_W'((int'(ptr) + k) % N);
      if (mask[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seven_seg_display_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | seven_seg_display_arbiter                                             |
// | Round-robin display sharing with a minimum hold time per owner.       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module seven_seg_display_arbiter
  import seven_seg_pkg::*;
#(
  parameter int                    NUM_REQ     = 4,
  parameter int                    HOLD_CYCLES = 100_000_000,
  parameter logic [DISPLAY_W-1:0]  IDLE_VAL    = IDLE_VAL_DEFAULT,
  parameter int                    ID_W        = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DISPLAY_W-1:0]   data_in,
  output logic [NUM_REQ-1:0]             grant,
  output logic [ID_W-1:0]                owner_id,
  output logic                           busy_out,
  output logic [DISPLAY_W-1:0]           val_out,
  output logic                           switch_pulse
);

  localparam logic [31:0] C_HOLD_MAX = 32'(HOLD_CYCLES - 1);

  arb_state_t           r_state, w_state_nxt;
  logic [ID_W-1:0]      r_owner, w_owner_nxt, r_ptr, w_pick_idx;
  logic [NUM_REQ-1:0]   r_grant, w_grant_nxt, w_mask;
  logic [31:0]          r_cnt, w_cnt_nxt;
  logic [DISPLAY_W-1:0] r_val, w_val_nxt;
  logic                 r_pulse, w_change, w_found, w_owner_req;

  // r_grant is all zero when idle, so this also covers the unowned case.
  assign w_mask      = req & ~r_grant;
  assign w_owner_req = req[r_owner];

  rr_picker #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_picker (
    .mask  (w_mask),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_pick_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    w_change    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_OWNED;
          w_owner_nxt = w_pick_idx;
          w_cnt_nxt   = '0;
          w_change    = 1'b1;
        end
      end
      ST_OWNED: begin
        // A dropped owner is released even if its hold has expired too.
        if (!w_owner_req || (r_cnt == C_HOLD_MAX && w_found)) begin
          w_change  = 1'b1;
          w_cnt_nxt = '0;
          if (w_found) begin
            w_owner_nxt = w_pick_idx;
          end else begin
            w_state_nxt = ST_IDLE;
            w_owner_nxt = '0;
          end
        end else if (r_cnt != C_HOLD_MAX) begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_owner_nxt = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_grant_nxt = '0;
    w_val_nxt   = IDLE_VAL;
    if (w_state_nxt == ST_OWNED) begin
      w_grant_nxt[w_owner_nxt] = 1'b1;
      w_val_nxt = data_in[DISPLAY_W*w_owner_nxt +: DISPLAY_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
      r_grant <= '0;
      r_cnt   <= '0;
      r_ptr   <= ID_W'(NUM_REQ - 1);
      r_val   <= IDLE_VAL;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_grant <= w_grant_nxt;
      r_cnt   <= w_cnt_nxt;
      r_val   <= w_val_nxt;
      r_pulse <= w_change;
      if (w_change && w_state_nxt == ST_OWNED) begin
        r_ptr <= w_owner_nxt;
      end
    end
  end

  assign grant        = r_grant;
  assign owner_id     = r_owner;
  assign busy_out     = (r_state == ST_OWNED);
  assign val_out      = r_val;
  assign switch_pulse = r_pulse;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_display_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_seven_seg_display_arbiter                                          |
// | Directed + randomized bench against a behavioural ownership model.    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_seven_seg_display_arbiter;

  localparam int NR   = 4;
  localparam int HOLD = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] req = '0;
  logic [63:0]   data_in = '0;
  logic [NR-1:0] grant;
  logic [1:0]    owner_id;
  logic          busy_out;
  logic [15:0]   val_out;
  logic          switch_pulse;

  int checks = 0;
  int failures = 0;

  seven_seg_display_arbiter #(
    .NUM_REQ     (NR),
    .HOLD_CYCLES (HOLD),
    .IDLE_VAL    (16'h0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .data_in      (data_in),
    .grant        (grant),
    .owner_id     (owner_id),
    .busy_out     (busy_out),
    .val_out      (val_out),
    .switch_pulse (switch_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner index (-1 = nobody), edges elapsed since grant.
  int          m_owner;
  int          m_age;
  int          m_ptr;
  logic [15:0] m_val;
  logic        m_pulse;

  function automatic int pick(input logic [NR-1:0] m, input int p);
    for (int k = 1; k <= NR; k++) begin
      if (m[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int nxt;
    logic [NR-1:0] others;
    if (!rst_n) begin
      m_owner <= -1;
      m_age   <= 0;
      m_ptr   <= NR - 1;
      m_val   <= 16'h0000;
      m_pulse <= 1'b0;
    end else begin
      others = req;
      if (m_owner >= 0) others[m_owner] = 1'b0;
      nxt = m_owner;
      if (m_owner < 0) begin
        if (req != 0) nxt = pick(req, m_ptr);
      end else if (!req[m_owner]) begin
        nxt = (others != 0) ? pick(others, m_ptr) : -1;
      end else if (m_age + 1 >= HOLD && others != 0) begin
        nxt = pick(others, m_ptr);
      end
      m_pulse <= (nxt != m_owner);
      if (nxt != m_owner) begin
        m_age <= 0;
        if (nxt >= 0) m_ptr <= nxt;
      end else begin
        m_age <= m_age + 1;
      end
      m_owner <= nxt;
      m_val   <= (nxt < 0) ? 16'h0000 : data_in[16*nxt +: 16];
    end
  end

  always @(negedge clk) begin
    logic [NR-1:0] eg;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    chk("model_grant", 64'(grant), 64'(eg));
    chk("model_owner_id", 64'(owner_id), (m_owner >= 0) ? 64'(m_owner) : 64'd0);
    chk("model_busy", 64'(busy_out), 64'(m_owner >= 0));
    chk("model_val", 64'(val_out), 64'(m_val));
    chk("model_pulse", 64'(switch_pulse), 64'(m_pulse));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int pulses;
    int held;

    // Reset state
    tick(); tick();
    chk("reset_grant", 64'(grant), 64'd0);
    chk("reset_val", 64'(val_out), 64'h0000);
    chk("reset_busy", 64'(busy_out), 64'd0);
    chk("reset_owner", 64'(owner_id), 64'd0);
    rst_n = 1'b1;

    // Single requester
    data_in[47:32] = 16'hBEEF;
    req = 4'b0100;
    pulses = 0;
    held = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (grant == 4'b0100) held++;
      if (switch_pulse) pulses++;
    end
    chk("single_held", 64'(held), 64'd50);
    chk("single_pulses", 64'(pulses), 64'd1);
    chk("single_val", 64'(val_out), 64'hBEEF);
    req = 4'b0000;
    tick();
    chk("single_drop_grant", 64'(grant), 64'd0);
    chk("single_drop_val", 64'(val_out), 64'h0000);
    chk("single_drop_pulse", 64'(switch_pulse), 64'd1);

    // Hold / preempt
    req = 4'b0001;
    tick();
    chk("hold_first_grant", 64'(grant), 64'b0001);
    tick(); tick();
    req = 4'b0011;
    n = 2;
    while (grant != 4'b0010 && n < 30) begin
      tick();
      n++;
    end
    chk("hold_preempt_edge", 64'(n), 64'd8);
    req = 4'b0000;
    tick();

    // Live data tracking
    data_in[31:16] = 16'h1234;
    req = 4'b0010;
    tick();
    chk("live_val_before", 64'(val_out), 64'h1234);
    data_in[31:16] = 16'h5678;
    chk("live_val_same_cycle", 64'(val_out), 64'h1234);
    tick();
    chk("live_val_after", 64'(val_out), 64'h5678);
    req = 4'b0000;
    tick();

    // Early release with no gap
    req = 4'b1000;
    tick();
    chk("early_owner3", 64'(grant), 64'b1000);
    req = 4'b1010;
    tick(); tick();
    chk("early_still_owner3", 64'(grant), 64'b1000);
    req = 4'b0010;
    tick();
    chk("early_handoff", 64'(grant), 64'b0010);
    chk("early_pulse", 64'(switch_pulse), 64'd1);

    // Async reset mid-ownership, then round-robin wrap from requester 0
    #2 rst_n = 1'b0;
    #1;
    chk("async_grant", 64'(grant), 64'd0);
    chk("async_busy", 64'(busy_out), 64'd0);
    chk("async_val", 64'(val_out), 64'h0000);
    chk("async_owner", 64'(owner_id), 64'd0);
    chk("async_pulse", 64'(switch_pulse), 64'd0);
    rst_n = 1'b1;
    data_in = 64'h4444_3333_2222_1111;
    req = 4'b1111;
    tick();
    chk("rr_first_grant", 64'(grant), 64'b0001);
    chk("rr_first_val", 64'(val_out), 64'h1111);
    for (int t = 1; t < 40; t++) begin
      tick();
      chk("rr_order", 64'(grant), 64'(1 << ((t / 8) % 4)));
    end

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3) == 0) req[$urandom_range(NR-1)] ^= 1'b1;
      if ($urandom_range(7) == 0) data_in[16*$urandom_range(NR-1) +: 16] = 16'($urandom);
      if ($urandom_range(299) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seven_seg_display_arbiter.md
# seven_seg_display_arbiter

Shares the single 4-digit seven-segment display between up to `NUM_REQ` requesters (switch value, event counter, debug status, …) by round-robin arbitration with a guaranteed minimum hold time per owner. It sits directly in front of `seven_seg_controller`. Its `val_out` drives the controller's `val_in`, and `busy_out` gates blanking. Each owner keeps the display for at least `HOLD_CYCLES` while it requests, so values stay readable.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `HOLD_CYCLES`, default 100_000_000: minimum ownership in clocks before preemption by another requester; must be ≥1.
- `IDLE_VAL`, default 16'h0000: `val_out` value when no owner.
- `ID_W`, default `$clog2(NUM_REQ)`: width of `owner_id`.

Ports:
- `clk`, input, 1: system clock, all logic on rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `req`, input, `NUM_REQ`: level request per requester; held high while the requester wants the display.
- `data_in`, input, `NUM_REQ*16`: requester i's 4 hex digits in `[16*i+15:16*i]`.
- `grant`, output, `NUM_REQ`: one-hot owner, or all zero when idle.
- `owner_id`, output, `ID_W`: binary index of owner; 0 when idle.
- `busy_out`, output, 1: high while an owner exists.
- `val_out`, output, 16: registered display value for the controller.
- `switch_pulse`, output, 1: one-cycle pulse on every ownership change, including idle→owned and owned→idle.

## Operation
- States: IDLE, OWNED. Reset (`rst_n`=0, async, any time incl. mid-ownership):
  - state=IDLE, `grant`=0, `owner_id`=0, `busy_out`=0, `val_out`=`IDLE_VAL`, `switch_pulse`=0.
  - hold counter = 0.
  - rr pointer = `NUM_REQ`-1, so requester 0 wins first.
- Round-robin pick: the first set bit of a candidate mask, searching from pointer+1 upward with wrap-around. The pointer loads the new owner's index on every grant.
- IDLE: if `req`≠0, pick from `req` → OWNED, grant winner, counter=0, pulse. Otherwise stay.
- OWNED, owner drops `req`: release in the same edge.
  - If other requests are pending, pick from `req` with the owner's bit masked → new owner, counter=0, pulse.
  - Otherwise → IDLE, pulse.
  - The hold time does not protect an owner that has dropped.
- OWNED, owner holds `req`:
  - Counter increments, saturating at `HOLD_CYCLES`-1.
  - When counter==`HOLD_CYCLES`-1 and another request is pending, pick from `req` with the owner masked → switch, counter=0, pulse.
  - With no other request, the owner keeps the display indefinitely.
- `val_out`: each edge loads `data_in` slice of the next owner (the owner being granted at that edge), or `IDLE_VAL` when the next state is IDLE. Owner data changes therefore track live with 1 cycle delay.
- Simultaneous events: several new requests in one cycle resolve by rr order only. A request arriving on the same edge the owner drops is eligible immediately. The owner dropping and hold expiry in the same cycle are treated as a drop.
- Requester bits ≥`NUM_REQ` do not exist. `grant` is always zero or one-hot.

## Timing
- Request to grant latency: `req` high before edge k → `grant`, `busy_out`, `owner_id`, `val_out` valid after edge k (1 cycle).
- Handoff has no idle gap: the old grant falls and the new grant rises at the same edge.
- Preemption: an owner granted at edge g that holds `req`, with another requester waiting, loses the grant at edge g+`HOLD_CYCLES`. With `HOLD_CYCLES`=1, preemption happens every cycle while contention persists.
- `switch_pulse` is high for exactly the cycle after the changing edge.
- All outputs are registered; there is no combinational input→output path.

## Structure
- Shared package `seven_seg_pkg`: state enum (IDLE, OWNED), `DIGIT_W`=4, `DISPLAY_W`=16, default `IDLE_VAL`.
- One combinational sub-module, `rr_picker` (params `N`; inputs `mask`, `ptr`; outputs `found`, `idx`). It is instantiated once with `mask`=`req & ~owner_onehot_if_owned`.
- Hold counter is 32 bits.

## Test plan
Bench parameters: `NUM_REQ`=4, `HOLD_CYCLES`=8.
- **Reset:** drive `rst_n` low mid-ownership, asynchronously between edges → all outputs reset immediately. After release with `req`=4'b1111 → `grant`=4'b0001, `val_out`=`data_in[15:0]`.
- **Single requester:** `req`=4'b0100, `data_in` slice 2 = 16'hBEEF held 50 cycles → `grant`=4'b0100 for all 50 cycles, `val_out`=16'hBEEF, one `switch_pulse`. Drop `req` → IDLE next cycle, `val_out`=16'h0000, pulse.
- **Hold/preempt:** req0 granted at edge g, req1 raised at g+2 → `grant`=4'b0010 exactly at edge g+8.
- **Round-robin wrap:** all four requesters held high → grant order 0,1,2,3,0, with 8 cycles each.
- **Early release:** owner 3 drops at its cycle 3 while req1 is pending → `grant`=4'b0010 on the next edge, with no gap cycle.
- **Live data:** owner's `data_in` changes 16'h1234→16'h5678 → `val_out` follows one cycle later.
